tx_frame_assemble: RTL
======================

// Module: tx_frame_assemble
// PURPOSE
//  Transmit-side mirror of the receive frame parser. Takes 64-bit frame words (DA onward, FCS included)
//  from the TX FIFO and drives the 64-bit XGMII-style txd64/txc8 lanes: start+preamble+SFD, data, terminator, idle/IFG.
//  Byte 0 of every word is on bits [63:56] / txc8[7]. Control codes: START 8'hdf, TERMINATE 8'hbf, SFD 8'hd5,
//  PREAMBLE 8'h55, ERROR 8'h7f, IDLE 8'he0. The start word is exactly what the RX SFD check accepts.
// PARAMETERS
//  TP         1   register delay for #TP on nonblocking assignments
//  IFG_WORDS  1   all-idle words (1..15) forced after the word holding TERMINATE, before the next start word
// PORTS
//  txclk          in   1   single clock
//  reset          in   1   asynchronous, active-high reset
//  tx_data        in   64  frame word; byte 0 on [63:56]
//  tx_valid       in   1   tx_data/tx_last/tx_last_bytes valid
//  tx_last        in   1   current word is the last word of the frame
//  tx_last_bytes  in   3   valid bytes in last word, 1..7; 0 means 8
//  tx_ready       out  1   word accepted on cycles where tx_valid & tx_ready
//  txd64          out  64  XGMII data lanes (registered)
//  txc8           out  8   XGMII control flags, bit 7 = lane [63:56] (registered)
//  tx_underrun    out  1   one-cycle pulse: frame aborted because tx_valid dropped mid-frame
// BEHAVIOUR
//  - Reset: state=IDLE, txd64={8{8'he0}}, txc8=8'hff, tx_ready=0, tx_underrun=0, IFG counter=0.
//  - FSM: IDLE, START, DATA, TERM, DROP, IFG. Outputs are registered: the word for state S appears one cycle after S is decoded.
//  - IDLE: drive idles, tx_ready=0. tx_valid=1 -> START.
//  - START: emit {8'hdf,8'h55 x6,8'hd5}, txc8=8'h80. tx_ready=0. -> DATA.
//  - DATA: tx_ready=1. On an accepted non-last word, emit tx_data with txc8=8'h00.
//  - DATA, accepted last word, k=tx_last_bytes in 1..7:
//    - Lanes 0..k-1 carry data, lane k carries TERMINATE, lanes >k carry IDLE.
//    - txc8 = 8'hff >> k (e.g. k=3 -> 8'h1f).
//    - -> IFG.
//  - DATA, accepted last word, k=0 (8 bytes): emit all data with txc8=8'h00, -> TERM.
//  - TERM: tx_ready=0. Emit {8'hbf,8'he0 x7}, txc8=8'hff. -> IFG.
//  - DATA, tx_valid=0 (underrun):
//    - Emit {8'h7f x7,8'hbf}, txc8=8'hff. Pulse tx_underrun.
//    - -> DROP; if the aborted word was not already the last word, tx_ready=1 in DROP.
//  - DROP: discard words until an accepted tx_last word. Drive idles. -> IFG.
//  - IFG:
//    - Drive idles for exactly IFG_WORDS cycles; the counter is loaded on entry.
//    - Then -> START if tx_valid, else -> IDLE.
//    - tx_ready=0 throughout, so a pending word waits without loss.
//  - Frames of one word (tx_last on the first DATA word) are legal.
//  - A word is never lost or duplicated: tx_ready is combinational from state, and data is sampled only on tx_valid & tx_ready.
//  - Reset asserted mid-frame: outputs return to reset values immediately. No terminator is emitted; the RX side treats this as a truncated frame.
// CONFIGURATION
//  - TX_STATS_EN defined:
//    - Adds outputs stat_frames[31:0] and stat_bytes[47:0], reset 0, wrap-around at max.
//    - stat_frames +1 on each terminator emitted for a non-aborted frame.
//    - stat_bytes += data bytes of that frame (8 per full word + k).
//    - Aborted frames update neither counter.
//  - TX_STATS_EN undefined: the ports and counters do not exist. All other behaviour is identical.
// TESTING
//  1. Reset then idle:
//     - Required: txd64=64'he0e0e0e0e0e0e0e0 and txc8=8'hff every cycle, tx_ready=0.
//  2. Frame of 8 words, tx_last_bytes=4:
//     - Start word 64'hdf555555555555d5 / 8'h80.
//     - 7 data words / 8'h00.
//     - Last word: 4 data bytes, then bf, e0e0e0, txc8=8'h0f.
//     - Then 1 idle word.
//  3. Frame ending with tx_last_bytes=0:
//     - Last data word with txc8=8'h00.
//     - Next word 64'hbfe0e0e0e0e0e0e0 / 8'hff.
//     - Then IFG.
//  4. Back-to-back frames with IFG_WORDS=3 and tx_valid held high:
//     - Exactly 3 idle words between the terminator word and the next start word.
//     - No words dropped (compare against a scoreboard).
//  5. tx_valid low for 1 cycle mid-frame:
//     - Word 64'h7f7f7f7f7f7f7fbf / 8'hff.
//     - tx_underrun pulses once.
//     - Remaining words up to tx_last are consumed with idles on the line.
//     - With TX_STATS_EN, stat_frames is unchanged.
//  6. Reset pulse during DATA:
//     - Next cycle shows idles / 8'hff, tx_ready=0.
//     - A new frame then starts cleanly with the start word.

Source files
------------

// File: rtl/tx_frame_assemble.sv
// tx_frame_assemble: turns 64-bit frame words into XGMII start/data/terminate/idle words.
// Optional macro TX_STATS_EN adds stat_frames / stat_bytes counters.
module tx_frame_assemble #(
   parameter int IFG_WORDS = 1
) (
   input  logic        txclk,
   input  logic        reset,
   input  logic [63:0] tx_data,
   input  logic        tx_valid,
   input  logic        tx_last,
   input  logic [2:0]  tx_last_bytes,
   output logic        tx_ready,
   output logic [63:0] txd64,
   output logic [7:0]  txc8,
   output logic        tx_underrun
`ifdef TX_STATS_EN
   ,
   output logic [31:0] stat_frames,
   output logic [47:0] stat_bytes
`endif
);

   localparam logic [63:0] C_IDLE_WORD  = 64'he0e0e0e0e0e0e0e0;
   localparam logic [63:0] C_START_WORD = 64'hdf555555555555d5;
   localparam logic [63:0] C_TERM_WORD  = 64'hbfe0e0e0e0e0e0e0;
   localparam logic [63:0] C_ERR_WORD   = 64'h7f7f7f7f7f7f7fbf;
   localparam logic [3:0]  C_IFG_LOAD   = IFG_WORDS[3:0];

   typedef enum logic [2:0] {
      S_IDLE  = 3'd0,
      S_START = 3'd1,
      S_DATA  = 3'd2,
      S_TERM  = 3'd3,
      S_DROP  = 3'd4,
      S_IFG   = 3'd5
   } state_t;

   state_t      r_state;
   state_t      w_next_state;
   logic [3:0]  r_ifg_cnt;
   logic [63:0] r_txd;
   logic [7:0]  r_txc;
   logic        r_underrun;
   logic [63:0] w_txd;
   logic [7:0]  w_txc;
   logic        w_underrun;
   logic [63:0] w_last_word;

   // Short last word: data lanes, then TERMINATE, then idles
   always_comb begin
      w_last_word = C_IDLE_WORD;
      for (int i = 0; i < 8; i++) begin
         if (i < int'(tx_last_bytes)) begin
            w_last_word[63-8*i -: 8] = tx_data[63-8*i -: 8];
         end else if (i == int'(tx_last_bytes)) begin
            w_last_word[63-8*i -: 8] = 8'hbf;
         end else begin
            w_last_word[63-8*i -: 8] = 8'he0;
         end
      end
   end

   always_comb begin
      w_next_state = r_state;
      w_txd        = C_IDLE_WORD;
      w_txc        = 8'hff;
      w_underrun   = 1'b0;
      tx_ready     = 1'b0;
      case (r_state)
         S_IDLE: begin
            if (tx_valid) begin
               w_next_state = S_START;
            end else begin
               w_next_state = S_IDLE;
            end
         end
         S_START: begin
            w_txd        = C_START_WORD;
            w_txc        = 8'h80;
            w_next_state = S_DATA;
         end
         S_DATA: begin
            tx_ready = 1'b1;
            if (!tx_valid) begin
               w_txd        = C_ERR_WORD;
               w_underrun   = 1'b1;
               w_next_state = S_DROP;
            end else if (tx_last && (tx_last_bytes != 3'd0)) begin
               w_txd        = w_last_word;
               w_txc        = 8'hff >> tx_last_bytes;
               w_next_state = S_IFG;
            end else if (tx_last) begin
               w_txd        = tx_data;
               w_txc        = 8'h00;
               w_next_state = S_TERM;
            end else begin
               w_txd = tx_data;
               w_txc = 8'h00;
            end
         end
         S_TERM: begin
            w_txd        = C_TERM_WORD;
            w_next_state = S_IFG;
         end
         S_DROP: begin
            // The rest of the aborted frame is drained so the FIFO realigns on the next frame
            tx_ready = 1'b1;
            if (tx_valid && tx_last) begin
               w_next_state = S_IFG;
            end else begin
               w_next_state = S_DROP;
            end
         end
         S_IFG: begin
            if (r_ifg_cnt > 4'd1) begin
               w_next_state = S_IFG;
            end else if (tx_valid) begin
               w_next_state = S_START;
            end else begin
               w_next_state = S_IDLE;
            end
         end
         default: begin
            w_next_state = S_IDLE;
         end
      endcase
   end

   always_ff @(posedge txclk or posedge reset) begin
      if (reset) begin
         r_state    <= S_IDLE;
         r_txd      <= C_IDLE_WORD;
         r_txc      <= 8'hff;
         r_underrun <= 1'b0;
      end else begin
         r_state    <= w_next_state;
         r_txd      <= w_txd;
         r_txc      <= w_txc;
         r_underrun <= w_underrun;
      end
   end

   always_ff @(posedge txclk or posedge reset) begin
      if (reset) begin
         r_ifg_cnt <= 4'd0;
      end else if ((r_state != S_IFG) && (w_next_state == S_IFG)) begin
         r_ifg_cnt <= C_IFG_LOAD;
      end else if ((r_state == S_IFG) && (r_ifg_cnt != 4'd0)) begin
         r_ifg_cnt <= r_ifg_cnt - 4'd1;
      end
   end

   assign txd64       = r_txd;
   assign txc8        = r_txc;
   assign tx_underrun = r_underrun;

`ifdef TX_STATS_EN
   logic [31:0] r_stat_frames;
   logic [47:0] r_stat_bytes;
   logic [47:0] r_frame_bytes;

   // Counters advance only when a terminator is issued for a frame that completed normally
   always_ff @(posedge txclk or posedge reset) begin
      if (reset) begin
         r_stat_frames <= 32'd0;
         r_stat_bytes  <= 48'd0;
         r_frame_bytes <= 48'd0;
      end else if (r_state == S_START) begin
         r_frame_bytes <= 48'd0;
      end else if ((r_state == S_DATA) && tx_valid) begin
         if (tx_last && (tx_last_bytes != 3'd0)) begin
            r_stat_frames <= r_stat_frames + 32'd1;
            r_stat_bytes  <= r_stat_bytes + r_frame_bytes + {45'd0, tx_last_bytes};
         end else begin
            r_frame_bytes <= r_frame_bytes + 48'd8;
         end
      end else if (r_state == S_TERM) begin
         r_stat_frames <= r_stat_frames + 32'd1;
         r_stat_bytes  <= r_stat_bytes + r_frame_bytes;
      end
   end

   assign stat_frames = r_stat_frames;
   assign stat_bytes  = r_stat_bytes;
`endif

endmodule
